sram_pattern_gen: RTL and testbench

Stimulus side of the SRAM self-test. It sweeps the full address space with writes of a selectable data pattern, then reads every address back. For each in-order read response it emits a one-cycle check strobe with the returned data and the regenerated expected data. These outputs feed the result checker's enable/read_data/expected_data inputs directly. It sits between the test top-level controller and the SRAM controller's request/response interface.

---
 rtl/sram_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_sram_pattern_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pattern_gen.sv
// SRAM self-test stimulus: write-sweep a pattern, read-sweep, strobe each response with regenerated data.
// Optional SRAM_PATTERN_GEN_LOOP_EN: restart the sweep with the next pattern instead of stopping in DONE.
module sram_pattern_gen #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           pattern_sel,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic                 req_we,
  output logic [ADDR_BITS-1:0] req_addr,
  output logic [DATA_BITS-1:0] req_wdata,
  input  logic                 rd_valid,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 check_en,
  output logic [DATA_BITS-1:0] check_read_data,
  output logic [DATA_BITS-1:0] expected_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pass_count
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

  localparam int CW = ADDR_BITS + 1;
  localparam int MW = (CW > 32) ? CW : 32;
  localparam logic [CW-1:0] LAST = {1'b0, {ADDR_BITS{1'b1}}};
  localparam logic [CW-1:0] ENDA = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [7:0] CB0 = 8'hA5;
  localparam logic [7:0] CB1 = 8'h5A;

  function automatic logic [DATA_BITS-1:0] pattern(input logic [ADDR_BITS-1:0] a,
                                                   input logic [1:0] sel);
    logic [ADDR_BITS+DATA_BITS-1:0] ext;
    logic [MW-1:0]                  sh;
    logic [DATA_BITS-1:0]           d;
    ext = {{DATA_BITS{1'b0}}, a};
    sh  = MW'(a) % MW'(DATA_BITS);
    d   = '0;
    case (sel)
      2'd0:    d = ext[DATA_BITS-1:0];
      2'd1:    d = ~ext[DATA_BITS-1:0];
      2'd2:    d = DATA_BITS'(1) << sh;
      default: for (int i = 0; i < DATA_BITS; i++) d[i] = a[0] ? CB1[i%8] : CB0[i%8];
    endcase
    return d;
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        wr_addr_q, rd_addr_q, exp_addr_q;
  logic [1:0]           pat_q;
  logic [15:0]          pass_q;
  logic                 chk_en_q;
  logic [DATA_BITS-1:0] chk_rd_q, chk_exp_q;
  logic                 hs, start_ok, chk_fire, drain_end;

  assign hs        = req_valid & req_ready;
  assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  // Only responses to outstanding reads count; anything else is noise.
  assign chk_fire  = rd_valid & ((state_q == S_READ) | (state_q == S_DRAIN)) &
                     (exp_addr_q != rd_addr_q);
  assign drain_end = (state_q == S_DRAIN) & (exp_addr_q == ENDA);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_WRITE;
      S_WRITE:        if (hs && wr_addr_q == LAST) state_d = S_READ;
      S_READ:         if (hs && rd_addr_q == LAST) state_d = S_DRAIN;
      S_DRAIN:
`ifdef SRAM_PATTERN_GEN_LOOP_EN
        if (exp_addr_q == ENDA) state_d = S_WRITE;
`else
        if (exp_addr_q == ENDA) state_d = S_DONE;
`endif
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state_q)
      S_WRITE: begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = wr_addr_q[ADDR_BITS-1:0];
        req_wdata = pattern(wr_addr_q[ADDR_BITS-1:0], pat_q);
      end
      S_READ: begin
        req_valid = 1'b1;
        req_addr  = rd_addr_q[ADDR_BITS-1:0];
      end
      default: ;
    endcase
    busy = (state_q == S_WRITE) | (state_q == S_READ) | (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      exp_addr_q <= '0;
      pat_q      <= '0;
      pass_q     <= '0;
      chk_en_q   <= 1'b0;
      chk_rd_q   <= '0;
      chk_exp_q  <= '0;
    end else begin
      if (start_ok) begin
        pat_q      <= pattern_sel;
        wr_addr_q  <= '0;
        rd_addr_q  <= '0;
        exp_addr_q <= '0;
      end else begin
        if (state_q == S_WRITE && hs) wr_addr_q <= wr_addr_q + 1'b1;
        if (state_q == S_READ && hs)  rd_addr_q <= rd_addr_q + 1'b1;
        if (chk_fire)                 exp_addr_q <= exp_addr_q + 1'b1;
`ifdef SRAM_PATTERN_GEN_LOOP_EN
        if (drain_end) begin
          pat_q      <= pat_q + 2'd1;
          wr_addr_q  <= '0;
          rd_addr_q  <= '0;
          exp_addr_q <= '0;
        end
`endif
      end
      chk_en_q <= chk_fire;
      if (chk_fire) begin
        chk_rd_q  <= rd_data;
        chk_exp_q <= pattern(exp_addr_q[ADDR_BITS-1:0], pat_q);
      end
      if (drain_end) pass_q <= pass_q + 16'd1;
    end
  end

  assign check_en        = chk_en_q;
  assign check_read_data = chk_rd_q;
  assign expected_data   = chk_exp_q;
  assign pass_count      = pass_q;

endmodule

// File: tb/tb_sram_pattern_gen.sv
// Scoreboard bench for sram_pattern_gen: memory/responder model, write checker, check-strobe monitor.
module tb_sram_pattern_gen;
  localparam int AB = 5;
  localparam int DB = 16;
  localparam int N  = 32;

  logic          clk, reset_n, start, req_valid, req_ready, req_we, rd_valid;
  logic [1:0]    pattern_sel;
  logic [AB-1:0] req_addr;
  logic [DB-1:0] req_wdata, rd_data, check_read_data, expected_data;
  logic          check_en, busy, done;
  logic [15:0]   pass_count;

  sram_pattern_gen #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pattern_sel(pattern_sel),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rd_valid(rd_valid), .rd_data(rd_data), .check_en(check_en),
    .check_read_data(check_read_data), .expected_data(expected_data), .busy(busy),
    .done(done), .pass_count(pass_count));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {logic [15:0] rd; logic [15:0] ex;} exp_t;
  typedef struct {int idx; logic [15:0] val;} spot_t;
  typedef struct {int due; logic [15:0] data;} rsp_t;
  exp_t  exp_q[$];
  spot_t spot_q[$];
  rsp_t  rsp_q[$];

  int tests = 0, fails = 0;
  int pulses = 0, mism = 0, wr_exp = 0, wr_pat = 0;
  bit stall_mode = 0, lat_mode = 0, fault_en = 0, stray = 0;
  logic [15:0] mem [N];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] tb_pat(int a, int p);
    logic [15:0] v;
    v = 16'(a);
    case (p)
      0:       return v;
      1:       return ~v;
      2:       return 16'h0001 << (a % 16);
      default: return (a % 2 == 1) ? 16'h5A5A : 16'hA5A5;
    endcase
  endfunction

  // Memory + in-order read responder; also checks writes and stall stability.
  initial begin
    int cyc = 0, last_due = 0, due;
    bit stall_prev = 0;
    logic [AB-1:0] s_addr;
    logic s_we;
    logic [15:0] s_wd, d;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        rsp_q.delete();
        rd_valid = 0;
        stall_prev = 0;
        continue;
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(req_valid), 1);
        chk("stall_addr", 32'(req_addr), 32'(s_addr));
        chk("stall_we", 32'(req_we), 32'(s_we));
        chk("stall_wdata", 32'(req_wdata), 32'(s_wd));
      end
      req_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      stall_prev = req_valid && !req_ready;
      s_addr = req_addr; s_we = req_we; s_wd = req_wdata;
      if (req_valid && req_ready) begin
        if (req_we) begin
          chk("wr_addr", 32'(req_addr), 32'(wr_exp[4:0]));
          chk("wr_data", 32'(req_wdata), 32'(tb_pat(wr_exp, wr_pat)));
          mem[req_addr] = req_wdata;
          wr_exp++;
          if (wr_exp == N) begin wr_exp = 0; wr_pat = (wr_pat + 1) % 4; end
        end else begin
          d = (fault_en && req_addr == 6) ? (mem[req_addr] & 16'hFFFE) : mem[req_addr];
          due = cyc + 1 + (lat_mode ? int'($urandom_range(0, 3)) : 0);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          rsp_q.push_back('{due, d});
        end
      end
      if (stray) begin
        rd_valid = 1; rd_data = 16'h1234;
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        rd_valid = 1; rd_data = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else begin
        rd_valid = 0; rd_data = 0;
      end
    end
  end

  // Check-strobe monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (check_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_check_en: got rd=%0h ex=%0h expected no strobe",
                   check_read_data, expected_data);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("chk_rd[%0d]", pulses), 32'(check_read_data), 32'(e.rd));
          chk($sformatf("chk_ex[%0d]", pulses), 32'(expected_data), 32'(e.ex));
        end
        if (spot_q.size() > 0 && spot_q[0].idx == pulses) begin
          chk($sformatf("spot_ex[%0d]", pulses), 32'(expected_data), 32'(spot_q[0].val));
          void'(spot_q.pop_front());
        end
        if (check_read_data !== expected_data) mism++;
        pulses++;
      end
    end
  end

  task automatic push_run(int p, bit fault);
    logic [15:0] v;
    for (int a = 0; a < N; a++) begin
      v = tb_pat(a, p);
      exp_q.push_back('{(fault && a == 6) ? (v & 16'hFFFE) : v, v});
    end
  endtask

  task automatic run_start(int p, bit fault);
    @(posedge clk); #1;
    start = 1; pattern_sel = 2'(p);
    wr_exp = 0; wr_pat = p; pulses = 0; mism = 0; fault_en = fault;
    spot_q.delete();
    push_run(p, fault);
    @(posedge clk); #1;
    start = 0; pattern_sel = ~2'(p);
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    chk(name, 32'(done), 1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_req_valid"}, 32'(req_valid), 0);
    chk({tag, "_req_we"}, 32'(req_we), 0);
    chk({tag, "_req_addr"}, 32'(req_addr), 0);
    chk({tag, "_req_wdata"}, 32'(req_wdata), 0);
    chk({tag, "_check_en"}, 32'(check_en), 0);
    chk({tag, "_check_rd"}, 32'(check_read_data), 0);
    chk({tag, "_expected"}, 32'(expected_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass_count"}, 32'(pass_count), 0);
  endtask

  task automatic end_of_run(string tag, int pc);
    chk({tag, "_pass_count"}, 32'(pass_count), 32'(pc));
    chk({tag, "_pulses"}, 32'(pulses), N);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_spots_left"}, 32'(spot_q.size()), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    bit found;
    reset_n = 0; start = 0; pattern_sel = 0; req_ready = 1; rd_valid = 0; rd_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1;
`ifdef SRAM_PATTERN_GEN_LOOP_EN
    run_start(0, 0);
    for (int p = 1; p < 4; p++) push_run(p, 0);
    n = 0;
    while (pass_count !== 16'd3 && n < 5000) begin @(posedge clk); #1; n++; end
    chk("loop_pass_count", 32'(pass_count), 3);
    chk("loop_done", 32'(done), 0);
    chk("loop_busy", 32'(busy), 1);
    chk("loop_pulses", 32'(pulses), 3 * N);
    repeat (40) @(posedge clk);
    #1;
    reset_n = 0;
    @(posedge clk); #1;
    chk_zero("loop_reset");
    reset_n = 1;
`else
    // Stray responses while idle must not strobe.
    stray = 1;
    repeat (3) @(posedge clk);
    #1; stray = 0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_stray_pulses", 32'(pulses), 0);

    stall_mode = 0; lat_mode = 0;
    run_start(0, 0);
    spot_q.push_back('{0, 16'h0000});
    spot_q.push_back('{31, 16'h001F});
    wait_done("p0_done");
    end_of_run("p0", 1);

    stray = 1;
    repeat (2) @(posedge clk);
    #1; stray = 0;
    @(posedge clk); #1;
    chk("done_stray_done", 32'(done), 1);
    chk("done_stray_pulses", 32'(pulses), N);

    stall_mode = 1; lat_mode = 1;
    run_start(2, 0);
    spot_q.push_back('{0, 16'h0001});
    spot_q.push_back('{17, 16'h0002});
    repeat (5) @(posedge clk);
    #1; start = 1; pattern_sel = 2'd1;
    @(posedge clk); #1; start = 0;
    repeat (60) @(posedge clk);
    #1; start = 1; pattern_sel = 2'd3;
    @(posedge clk); #1; start = 0;
    wait_done("p2_done");
    end_of_run("p2", 2);

    stall_mode = 0; lat_mode = 0;
    run_start(3, 1);
    spot_q.push_back('{6, 16'hA5A5});
    wait_done("p3_done");
    end_of_run("p3", 3);
    chk("p3_mismatches", 32'(mism), 1);
    fault_en = 0;

    run_start(1, 0);
    n = 0; found = 0;
    while (n < 500 && !found) begin
      if (req_valid && !req_we && req_addr == 5'd9) found = 1;
      else begin @(posedge clk); #1; n++; end
    end
    chk("reach_read9", 32'(found), 1);
    reset_n = 0;
    @(posedge clk); #1;
    chk_zero("midrun_reset");
    exp_q.delete();
    spot_q.delete();
    reset_n = 1;

    run_start(1, 0);
    spot_q.push_back('{0, 16'hFFFF});
    spot_q.push_back('{9, 16'hFFF6});
    wait_done("rerun_done");
    end_of_run("rerun", 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
